fb_sweep_sequencer: RTL
=======================

Name: fb_sweep_sequencer

Overview:
- Initiator for the datapath's start/instruction/finished command handshake.
- Walks every framebuffer pixel in raster order (x inner, y outer) and issues one command per pixel.
- Clear mode issues DRAW with write-enable and a fill colour; refresh mode issues DISPLAY, which causes the datapath to plot to the VGA adapter.
- Sits between the top-level control FSM and the datapath; holds the datapath command port for a whole frame.

Parameters:
- SCREEN_W, 160, pixels per row; x range is 0..SCREEN_W-1.
- SCREEN_H, 120, rows; y range is 0..SCREEN_H-1.
- FRAME_CNT_W, 16, width of the frame counter.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- go  in  1  start a sweep; sampled only in IDLE.
- mode  in  1  0 = refresh (DISPLAY), 1 = clear (DRAW); latched on go.
- fill_colour  in  COLOUR_WIDTH(3)  clear colour; latched on go.
- abort  in  1  request early stop.
- dp_finished  in  1  datapath idle/complete flag.
- dp_start  out  1  one-cycle command strobe to the datapath.
- dp_instruction  out  INSTRUCTION_WIDTH(32)  command word.
- busy  out  1  high from the cycle after go is accepted until DONE.
- done  out  1  one-cycle pulse when a sweep completes or is aborted.
- aborted  out  1  qualifies done; high in the same cycle if the sweep ended by abort.
- frame_count  out  FRAME_CNT_W  number of fully completed sweeps; wraps.

Behaviour:
- Reset values: dp_start=0, dp_instruction=0, busy=0, done=0, aborted=0, frame_count=0, x=y=0, state=IDLE. Reset mid-transaction returns to IDLE immediately; no further strobes.
- Instruction packing:
  - [OPCODE_WIDTH-1:0] = opcode.
  - [11:4] = x, [18:12] = y.
  - [21:19] = colour (clear mode only).
  - [22] = 1 in clear mode, 0 in refresh mode.
  - All other bits 0.
- dp_instruction is registered and stable from ISSUE until the following ISSUE.
- IDLE:
  - go=1 and abort=0 latch mode/fill_colour, zero x and y, then go to ISSUE.
  - go with abort in the same cycle is ignored.
- ISSUE:
  - Wait for dp_finished=1.
  - In that cycle drive dp_start=1 for exactly one cycle with the current instruction, then go to WAIT_ACK.
- WAIT_ACK:
  - Ignore dp_finished=1; it is still high during the cycle after the strobe.
  - On dp_finished=0, go to WAIT_DONE.
  - The datapath holds finished low for at least one cycle, so this state is never skipped.
- WAIT_DONE: on dp_finished=1, go to ADVANCE.
- ADVANCE:
  - If x < SCREEN_W-1: x+1.
  - Else x=0 and y+1.
  - If the pixel just completed was (SCREEN_W-1, SCREEN_H-1): increment frame_count (wraps), then go to DONE.
  - Else if an abort is latched: go to DONE with aborted=1.
  - Else: go to ISSUE.
- abort is latched when seen in any non-IDLE state. It never truncates an in-flight datapath transaction. It takes effect only in ADVANCE. An abort raised during the final pixel still counts the frame and reports aborted=0.
- DONE: pulse done for one cycle, clear the abort latch and busy, then go to IDLE.
- Minimum per-pixel cost is 4 cycles plus datapath latency: ISSUE, WAIT_ACK, WAIT_DONE, ADVANCE.
- Coordinate arithmetic is unsigned. x is 8 bits and y is 7 bits, so SCREEN_W ≤ 256 and SCREEN_H ≤ 128 must hold; this is enforced by a compile-time check.

Optional Feature:
- Macro: FB_SWEEP_CONTINUOUS_EN.
- Defined:
  - A completed refresh-mode sweep goes from DONE directly to ISSUE with x=y=0, unless abort is latched or go=0 in the DONE cycle.
  - done still pulses each frame and frame_count still increments.
  - busy stays high across the frame boundary.
  - Clear-mode sweeps never loop.
- Undefined: DONE always returns to IDLE, and the go level in DONE is ignored.

Decomposition:
- Shared constants header holds:
  - OPCODE_DRAW, OPCODE_DISPLAY, OPCODE_WIDTH.
  - INSTRUCTION_WIDTH, COLOUR_WIDTH.
  - X/Y_COORD_WIDTH, SCREEN_WIDTH/HEIGHT.
  - New: field offsets X_LSB=4, Y_LSB=12, COLOUR_LSB=19, FBWE_BIT=22.
  - State encodings for this block.
- One natural sub-module: dp_cmd_issuer, which owns the ISSUE/WAIT_ACK/WAIT_DONE handshake. Interface: req/instruction in, ack pulse out. It is reusable by future NN-memory sequencers.
- The raster counter stays in the top module.

Test Plan:
- Model datapath: finished drops 1 cycle after start and rises after a configurable N cycles. SCREEN_W=4, SCREEN_H=2, mode=0, go pulse, N=2 → exactly 8 strobes with (x,y) = (0,0)…(3,0),(0,1)…(3,1). Opcode is DISPLAY and bit22=0 on every strobe. One done pulse, aborted=0, frame_count=1.
- Clear: mode=1, fill_colour=3'b101 → 8 DRAW strobes, each with bits[21:19]=101 and bit22=1. frame_count=1.
- Handshake robustness: hold dp_finished=0 for 5 cycles before the first ISSUE, and use N=0 (finished low for exactly one cycle) → no strobe while finished=0. Never a second strobe before finished has gone low then high.
- Abort during pixel (1,0) → (1,0) completes and no strobe for (2,0). done pulses with aborted=1 and frame_count unchanged. A go pulse 1 cycle later starts a new sweep from (0,0).
- go while busy and go+abort in IDLE → both ignored; strobe count unchanged.
- Reset asserted in WAIT_DONE → next cycle dp_start=0, busy=0, frame_count=0. After release, a go starts at (0,0).
- Built with FB_SWEEP_CONTINUOUS_EN, refresh mode, go held high → 3 consecutive frames with no gap in busy. frame_count=3. Dropping go ends the sweep at the next frame boundary.

Source files
------------

// File: rtl/fb_sweep_sequencer_pkg.sv
// Shared constants for the framebuffer sweep sequencer: opcodes, instruction field layout,
// screen geometry defaults and state encodings.
package fb_sweep_sequencer_pkg;

  localparam int OPCODE_WIDTH      = 4;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int COLOUR_WIDTH      = 3;
  localparam int X_COORD_WIDTH     = 8;
  localparam int Y_COORD_WIDTH     = 7;
  localparam int SCREEN_WIDTH      = 160;
  localparam int SCREEN_HEIGHT     = 120;

  localparam int X_LSB      = 4;
  localparam int Y_LSB      = 12;
  localparam int COLOUR_LSB = 19;
  localparam int FBWE_BIT   = 22;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW    = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = 4'd2;

  typedef enum logic [1:0] {
    SWEEP_IDLE,
    SWEEP_ISSUE,
    SWEEP_ADVANCE,
    SWEEP_DONE
  } sweep_state_t;

  typedef enum logic [1:0] {
    ISSUER_READY,
    ISSUER_WAIT_ACK,
    ISSUER_WAIT_DONE
  } issuer_state_t;

  // Clear mode carries colour and framebuffer write-enable; refresh leaves those bits zero.
  function automatic logic [INSTRUCTION_WIDTH-1:0] pack_instruction(
    input logic [X_COORD_WIDTH-1:0] x,
    input logic [Y_COORD_WIDTH-1:0] y,
    input logic                     clear,
    input logic [COLOUR_WIDTH-1:0]  colour
  );
    logic [INSTRUCTION_WIDTH-1:0] word;
    word = '0;
    word[OPCODE_WIDTH-1:0]           = clear ? OPCODE_DRAW : OPCODE_DISPLAY;
    word[X_LSB +: X_COORD_WIDTH]     = x;
    word[Y_LSB +: Y_COORD_WIDTH]     = y;
    if (clear) begin
      word[COLOUR_LSB +: COLOUR_WIDTH] = colour;
      word[FBWE_BIT]                   = 1'b1;
    end
    return word;
  endfunction

endpackage

// File: rtl/fb_sweep_sequencer_dp_cmd_issuer.sv
// Start/instruction/finished handshake initiator: one strobe per req, ack once the
// datapath has dropped and re-raised finished.
module fb_sweep_sequencer_dp_cmd_issuer
  import fb_sweep_sequencer_pkg::*;
(
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         req,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         dp_finished,
  output logic                         dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  output logic                         ack
);

  issuer_state_t state, state_nxt;

  always_ff @(posedge clock) begin
    if (!resetn) state <= ISSUER_READY;
    else         state <= state_nxt;
  end

  // finished is still high the cycle after the strobe, so WAIT_ACK must see it low first.
  always_comb begin
    state_nxt = state;
    dp_start  = 1'b0;
    ack       = 1'b0;
    case (state)
      ISSUER_READY: begin
        if (req && dp_finished) begin
          dp_start  = 1'b1;
          state_nxt = ISSUER_WAIT_ACK;
        end
      end
      ISSUER_WAIT_ACK: begin
        if (!dp_finished) state_nxt = ISSUER_WAIT_DONE;
      end
      ISSUER_WAIT_DONE: begin
        if (dp_finished) begin
          ack       = 1'b1;
          state_nxt = ISSUER_READY;
        end
      end
      default: state_nxt = ISSUER_READY;
    endcase
  end

  assign dp_instruction = instruction;

endmodule

// File: rtl/fb_sweep_sequencer.sv
// Raster sweep over the framebuffer issuing one DRAW (clear) or DISPLAY (refresh) per pixel.
// Optional FB_SWEEP_CONTINUOUS_EN: refresh sweeps loop back to (0,0) while go stays high.
module fb_sweep_sequencer
  import fb_sweep_sequencer_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_WIDTH,
  parameter int SCREEN_H    = SCREEN_HEIGHT,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         go,
  input  logic                         mode,
  input  logic [COLOUR_WIDTH-1:0]      fill_colour,
  input  logic                         abort,
  input  logic                         dp_finished,
  output logic                         dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [FRAME_CNT_W-1:0]       frame_count
);

  if (SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 1 || SCREEN_H > 128) begin : g_geometry_check
    $error("fb_sweep_sequencer: screen geometry does not fit the coordinate widths");
  end

  localparam logic [X_COORD_WIDTH-1:0] X_LAST = X_COORD_WIDTH'(SCREEN_W - 1);
  localparam logic [Y_COORD_WIDTH-1:0] Y_LAST = Y_COORD_WIDTH'(SCREEN_H - 1);

  sweep_state_t                 state, state_nxt;
  logic [X_COORD_WIDTH-1:0]     x_q, x_nxt;
  logic [Y_COORD_WIDTH-1:0]     y_q, y_nxt;
  logic                         mode_q;
  logic [COLOUR_WIDTH-1:0]      colour_q;
  logic                         abort_q;
  logic                         aborted_q;
  logic                         busy_q;
  logic [FRAME_CNT_W-1:0]       frame_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic                         accept;
  logic                         restart;
  logic                         last_px;
  logic                         abort_seen;
  logic                         ack;

  assign last_px    = (x_q == X_LAST) && (y_q == Y_LAST);
  assign abort_seen = abort_q | abort;

  always_comb begin
    x_nxt = x_q + X_COORD_WIDTH'(1);
    y_nxt = y_q;
    if (x_q == X_LAST) begin
      x_nxt = '0;
      y_nxt = y_q + Y_COORD_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= SWEEP_IDLE;
    else         state <= state_nxt;
  end

  // The final pixel always counts the frame, even with an abort pending.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    restart   = 1'b0;
    case (state)
      SWEEP_IDLE: begin
        if (go && !abort) begin
          accept    = 1'b1;
          state_nxt = SWEEP_ISSUE;
        end
      end
      SWEEP_ISSUE: begin
        if (ack) state_nxt = SWEEP_ADVANCE;
      end
      SWEEP_ADVANCE: begin
        if (last_px || abort_seen) state_nxt = SWEEP_DONE;
        else                       state_nxt = SWEEP_ISSUE;
      end
      SWEEP_DONE: begin
        state_nxt = SWEEP_IDLE;
`ifdef FB_SWEEP_CONTINUOUS_EN
        if (!mode_q && go && !abort_seen) begin
          restart   = 1'b1;
          state_nxt = SWEEP_ISSUE;
        end
`endif
      end
      default: state_nxt = SWEEP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= 1'b0;
      colour_q  <= '0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= '0;
      instr_q   <= '0;
    end else begin
      if (state == SWEEP_DONE)                     abort_q <= 1'b0;
      else if (state != SWEEP_IDLE && abort)       abort_q <= 1'b1;

      if (accept) begin
        mode_q   <= mode;
        colour_q <= fill_colour;
        busy_q   <= 1'b1;
        x_q      <= '0;
        y_q      <= '0;
        instr_q  <= pack_instruction('0, '0, mode, fill_colour);
      end

      if (state == SWEEP_DONE) begin
        busy_q <= restart;
        if (restart) begin
          x_q     <= '0;
          y_q     <= '0;
          instr_q <= pack_instruction('0, '0, mode_q, colour_q);
        end
      end

      if (state == SWEEP_ADVANCE) begin
        x_q       <= x_nxt;
        y_q       <= y_nxt;
        aborted_q <= !last_px && abort_seen;
        if (last_px) frame_q <= frame_q + FRAME_CNT_W'(1);
        if (state_nxt == SWEEP_ISSUE) instr_q <= pack_instruction(x_nxt, y_nxt, mode_q, colour_q);
      end
    end
  end

  fb_sweep_sequencer_dp_cmd_issuer u_issuer (
    .clock          (clock),
    .resetn         (resetn),
    .req            (state == SWEEP_ISSUE),
    .instruction    (instr_q),
    .dp_finished    (dp_finished),
    .dp_start       (dp_start),
    .dp_instruction (dp_instruction),
    .ack            (ack)
  );

  assign busy        = busy_q;
  assign done        = (state == SWEEP_DONE);
  assign aborted     = done & aborted_q;
  assign frame_count = frame_q;

endmodule
